// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: 2-entry in-order buffer between the ALU and the
// register-file write port, with flag retirement and operand forwarding.
module alu_wb_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_neg,
  input  logic              in_ovf,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_wen,
  input  logic              in_setflags,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RA_W-1:0]   wb_rd,
  output logic              wb_wen,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  output logic              sticky_ovf,
  input  logic              sticky_clr,
  input  logic [RA_W-1:0]   src_a_addr,
  input  logic [RA_W-1:0]   src_b_addr,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_a_data,
  output logic [DATA_W-1:0] fwd_b_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RA_W-1:0]   rd;
    logic              wen;
    logic              sf;
    logic              z;
    logic              n;
    logic              v;
  } entry_t;

  entry_t     buf_r [2];
  logic       head_r;
  logic       tail_r;
  logic [1:0] count_r;

  logic       push_s;
  logic       pop_s;
  logic [1:0] count_nxt_s;
  entry_t     in_ent_s;
  entry_t     head_ent_s;
  entry_t     young_ent_s;
  entry_t     old_ent_s;
  logic       young_ok_s;
  logic       old_ok_s;
  logic [DATA_W:0] fwd_a_s;
  logic [DATA_W:0] fwd_b_s;

  // Youngest matching buffered entry wins; r0 and non-writing entries never forward.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [RA_W-1:0] addr,
    input entry_t          young,
    input logic            young_ok,
    input entry_t          old,
    input logic            old_ok
  );
    logic [DATA_W:0] res;
    res = '0;
    if (addr == '0) begin
      res = '0;
    end else if (young_ok && young.wen && (young.rd == addr)) begin
      res = {1'b1, young.data};
    end else if (old_ok && old.wen && (old.rd == addr)) begin
      res = {1'b1, old.data};
    end else begin
      res = '0;
    end
    return res;
  endfunction

  // Handshake decode and next occupancy.
  always_comb begin
    in_ent_s    = '{data: in_result, rd: in_rd, wen: in_wen, sf: in_setflags,
                    z: in_zero, n: in_neg, v: in_ovf};
    push_s      = in_valid && (count_r < 2'd2);
    pop_s       = wb_ready && (count_r != 2'd0);
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Head presentation and forwarding candidates; the entry before tail is the youngest.
  always_comb begin
    head_ent_s  = buf_r[head_r];
    young_ent_s = buf_r[~tail_r];
    old_ent_s   = buf_r[tail_r];
    young_ok_s  = (count_r != 2'd0);
    old_ok_s    = (count_r == 2'd2);
    fwd_a_s     = fwd_lookup(src_a_addr, young_ent_s, young_ok_s, old_ent_s, old_ok_s);
    fwd_b_s     = fwd_lookup(src_b_addr, young_ent_s, young_ok_s, old_ent_s, old_ok_s);
  end

  assign wb_data    = head_ent_s.data;
  assign wb_rd      = head_ent_s.rd;
  assign wb_wen     = head_ent_s.wen && (head_ent_s.rd != '0);
  assign fwd_a_hit  = fwd_a_s[DATA_W];
  assign fwd_a_data = fwd_a_s[DATA_W-1:0];
  assign fwd_b_hit  = fwd_b_s[DATA_W];
  assign fwd_b_data = fwd_b_s[DATA_W-1:0];

  // Buffer storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_r[i] <= '0;
      end
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (push_s) begin
        buf_r[tail_r] <= in_ent_s;
        tail_r        <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      count_r <= count_nxt_s;
    end
  end

  // Registered handshake status, derived from next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b1;
      wb_valid <= 1'b0;
    end else begin
      in_ready <= (count_nxt_s != 2'd2);
      wb_valid <= (count_nxt_s != 2'd0);
    end
  end

  // Architectural flags, sticky overflow and retire counter update only on retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_v     <= 1'b0;
      sticky_ovf <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (pop_s && head_ent_s.sf) begin
        flag_z <= head_ent_s.z;
        flag_n <= head_ent_s.n;
        flag_v <= head_ent_s.v;
      end
      if (pop_s && head_ent_s.sf && head_ent_s.v) begin
        sticky_ovf <= 1'b1;
      end else if (sticky_clr) begin
        sticky_ovf <= 1'b0;
      end
      if (pop_s) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: expected entries queued at push, checked at
// the head, with a reference model of flags, sticky overflow and retire count.
module tb_alu_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero, in_neg, in_ovf;
  logic [4:0]  in_rd;
  logic        in_wen, in_setflags;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic        flag_z, flag_n, flag_v, sticky_ovf, sticky_clr;
  logic [4:0]  src_a_addr, src_b_addr;
  logic        fwd_a_hit, fwd_b_hit;
  logic [31:0] fwd_a_data, fwd_b_data;
  logic [31:0] retire_cnt;

  alu_wb_stage #(.DATA_W(32), .RA_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_neg(in_neg), .in_ovf(in_ovf),
    .in_rd(in_rd), .in_wen(in_wen), .in_setflags(in_setflags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_wen(wb_wen),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen, sf, z, n, v;
  } ent_t;

  ent_t        sb_q[$];
  logic        m_z, m_n, m_v, m_sticky;
  logic [31:0] m_cnt;
  logic        accepted;
  int          total = 0;
  int          bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic wen, input logic sf, input logic z, input logic n,
                       input logic o);
    in_valid = v; in_result = res; in_rd = rd; in_wen = wen;
    in_setflags = sf; in_zero = z; in_neg = n; in_ovf = o;
  endtask

  task automatic model_fwd(input logic [4:0] addr, output logic hit, output logic [31:0] data);
    hit = 1'b0;
    data = 32'h0;
    if (addr != 5'd0) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (!hit && sb_q[i].wen && sb_q[i].rd == addr) begin
          hit = 1'b1;
          data = sb_q[i].data;
        end
      end
    end
  endtask

  // One clock: check pre-edge outputs, advance the model, check post-edge state.
  task automatic step();
    ent_t        e;
    logic        do_push, do_pop, h;
    logic [31:0] d;
    #1;
    check_val("in_ready", {31'd0, in_ready}, {31'd0, sb_q.size() < 2});
    check_val("wb_valid", {31'd0, wb_valid}, {31'd0, sb_q.size() != 0});
    if (sb_q.size() != 0) begin
      check_val("wb_data", wb_data, sb_q[0].data);
      check_val("wb_rd", {27'd0, wb_rd}, {27'd0, sb_q[0].rd});
      check_val("wb_wen", {31'd0, wb_wen}, {31'd0, sb_q[0].wen && sb_q[0].rd != 5'd0});
    end
    model_fwd(src_a_addr, h, d);
    check_val("fwd_a_hit", {31'd0, fwd_a_hit}, {31'd0, h});
    check_val("fwd_a_data", fwd_a_data, d);
    model_fwd(src_b_addr, h, d);
    check_val("fwd_b_hit", {31'd0, fwd_b_hit}, {31'd0, h});
    check_val("fwd_b_data", fwd_b_data, d);
    do_push  = in_valid && sb_q.size() < 2;
    do_pop   = wb_ready && sb_q.size() != 0;
    accepted = do_push && !rst;
    if (rst) begin
      sb_q.delete();
      m_z = 1'b0; m_n = 1'b0; m_v = 1'b0; m_sticky = 1'b0; m_cnt = 32'd0;
    end else begin
      if (do_pop) begin
        e = sb_q.pop_front();
        if (e.sf) begin
          m_z = e.z; m_n = e.n; m_v = e.v;
        end
        m_cnt = m_cnt + 32'd1;
        if (e.sf && e.v) m_sticky = 1'b1;
        else if (sticky_clr) m_sticky = 1'b0;
      end else if (sticky_clr) begin
        m_sticky = 1'b0;
      end
      if (do_push) begin
        e.data = in_result; e.rd = in_rd; e.wen = in_wen; e.sf = in_setflags;
        e.z = in_zero; e.n = in_neg; e.v = in_ovf;
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_val("flag_z", {31'd0, flag_z}, {31'd0, m_z});
    check_val("flag_n", {31'd0, flag_n}, {31'd0, m_n});
    check_val("flag_v", {31'd0, flag_v}, {31'd0, m_v});
    check_val("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, m_sticky});
    check_val("retire_cnt", retire_cnt, m_cnt);
  endtask

  initial begin
    logic [31:0] cnt_before;
    rst = 1'b1; wb_ready = 1'b0; sticky_clr = 1'b0;
    src_a_addr = 5'd0; src_b_addr = 5'd0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_z = 1'b0; m_n = 1'b0; m_v = 1'b0; m_sticky = 1'b0; m_cnt = 32'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_wb_data", wb_data, 32'd0);
    check_val("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check_val("rst_cnt", retire_cnt, 32'd0);
    check_val("rst_flags", {28'd0, flag_z, flag_n, flag_v, sticky_ovf}, 32'd0);
    check_val("rst_hits", {30'd0, fwd_a_hit, fwd_b_hit}, 32'd0);

    // single push then retire
    wb_ready = 1'b1;
    drive(1'b1, 32'h0000_0005, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_val("t1_valid", {31'd0, wb_valid}, 32'd1);
    check_val("t1_data", wb_data, 32'h5);
    check_val("t1_rd", {27'd0, wb_rd}, 32'd3);
    check_val("t1_wen", {31'd0, wb_wen}, 32'd1);
    in_valid = 1'b0;
    step();
    check_val("t1_flag_z", {31'd0, flag_z}, 32'd0);
    check_val("t1_cnt", retire_cnt, 32'd1);

    // back-pressure: A, B fill; C held until space
    wb_ready = 1'b0;
    drive(1'b1, 32'h0000_00A0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0000_00B0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_val("bp_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h0000_00C0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_val("bp_held", {31'd0, accepted}, 32'd0);
    wb_ready = 1'b1;
    step();
    check_val("bp_still_held", {31'd0, accepted}, 32'd0);
    step();
    check_val("bp_c_taken", {31'd0, accepted}, 32'd1);
    in_valid = 1'b0;
    step();
    step();
    check_val("bp_cnt", retire_cnt, 32'd4);

    // forwarding: youngest match wins, r0 never hits
    wb_ready = 1'b0;
    drive(1'b1, 32'h0000_0011, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0000_0022, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0; src_a_addr = 5'd7; src_b_addr = 5'd0;
    #1;
    check_val("fwd_young_hit", {31'd0, fwd_a_hit}, 32'd1);
    check_val("fwd_young_data", fwd_a_data, 32'h22);
    step();
    wb_ready = 1'b1;
    step();
    step();
    wb_ready = 1'b0;
    drive(1'b1, 32'h0000_0033, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    check_val("fwd_r0_hit", {31'd0, fwd_b_hit}, 32'd0);
    wb_ready = 1'b1;
    step();

    // sticky set beats same-cycle clear; ovf without setflags is ignored
    wb_ready = 1'b0;
    drive(1'b1, 32'h0000_0044, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0; wb_ready = 1'b1; sticky_clr = 1'b1;
    step();
    check_val("stk_set_wins", {31'd0, sticky_ovf}, 32'd1);
    check_val("stk_flag_v", {31'd0, flag_v}, 32'd1);
    step();
    check_val("stk_cleared", {31'd0, sticky_ovf}, 32'd0);
    sticky_clr = 1'b0;
    drive(1'b1, 32'h0000_0055, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    check_val("nosf_flag_v", {31'd0, flag_v}, 32'd1);
    check_val("nosf_sticky", {31'd0, sticky_ovf}, 32'd0);

    // write to r0 still retires and sets flags
    wb_ready = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    check_val("r0_wen", {31'd0, wb_wen}, 32'd0);
    cnt_before = m_cnt;
    wb_ready = 1'b1;
    step();
    check_val("r0_flag_n", {31'd0, flag_n}, 32'd1);
    check_val("r0_cnt", retire_cnt, cnt_before + 32'd1);

    // reset with two entries in flight
    wb_ready = 1'b0;
    drive(1'b1, 32'h0000_0066, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b1, 32'h0000_0077, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    in_valid = 1'b1; wb_ready = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_val("mrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_val("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("mrst_cnt", retire_cnt, 32'd0);
    check_val("mrst_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
    for (int i = 0; i < 3; i++) step();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(1, 0) == 1, $urandom, 5'($urandom_range(3, 0)),
            $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
            $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
            $urandom_range(1, 0) == 1);
      wb_ready   = $urandom_range(2, 0) != 0;
      sticky_clr = $urandom_range(7, 0) == 0;
      src_a_addr = 5'($urandom_range(3, 0));
      src_b_addr = 5'($urandom_range(3, 0));
      rst        = $urandom_range(99, 0) == 0;
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Execute-to-writeback stage directly downstream of the 32-bit ALU.
- Captures ALU result, Zero/Neg/overflow flags and destination info into a 2-entry buffer with valid/ready handshakes.
- Retires entries in order to the register-file write port and updates the architectural flag register and sticky overflow.
- Provides operand-forwarding lookups back to the ALU source-operand muxes.

Parameters:
- DATA_W, 32, width of result and forwarded data.
- RA_W, 5, register address width.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid ALU result.
- in_ready  out  1  stage can accept; equals (count < 2).
- in_result  in  DATA_W  ALU result.
- in_zero / in_neg / in_ovf  in  1 each  ALU flags for this result.
- in_rd  in  RA_W  destination register.
- in_wen  in  1  result is written to the register file.
- in_setflags  in  1  result updates architectural flags.
- wb_valid  out  1  head entry presented.
- wb_ready  in  1  register file accepts head.
- wb_data  out  DATA_W  head result.
- wb_rd  out  RA_W  head destination.
- wb_wen  out  1  head in_wen AND (rd != 0).
- flag_z / flag_n / flag_v  out  1 each  architectural flags.
- sticky_ovf  out  1  sticky overflow.
- sticky_clr  in  1  clears sticky_ovf.
- src_a_addr / src_b_addr  in  RA_W  operand lookup addresses.
- fwd_a_hit / fwd_b_hit  out  1  buffered value available.
- fwd_a_data / fwd_b_data  out  DATA_W  forwarded value.
- retire_cnt  out  CNT_W  retired entries, wraps.

Behaviour:
- Reset: count=0, wb_valid=0, in_ready=1, flags=0, sticky_ovf=0, retire_cnt=0, fwd hits=0, wb_data/wb_rd=0.
- Storage: 2-entry in-order FIFO (head/tail pointers, 1-bit each, plus 2-bit count).
- Push when in_valid & in_ready.
  - An entry accepted on edge N appears at wb_valid after edge N; minimum latency is 1 cycle.
  - There is no combinational pass-through.
- Pop when wb_valid & wb_ready.
- Push and pop in the same cycle with count=1: count stays 1; the new entry becomes head after the edge.
- Full (count=2): in_ready=0; pop still allowed; in_ready rises the cycle after the pop.
- Empty: wb_valid=0; wb_ready is ignored; wb_data holds its last value (don't-care).
- Pointer wrap: pointers wrap 1 to 0; order is preserved across wrap.
- On pop of an entry:
  - If its setflags=1: flag_z/n/v <= entry zero/neg/ovf.
  - If its setflags=1 and ovf=1: sticky_ovf <= 1.
  - retire_cnt increments by 1 on every pop, wrapping 2^CNT_W-1 to 0.
- Flags are never updated at push; only at retire.
- sticky_clr and a same-cycle sticky set: set wins; sticky_ovf=1.
- sticky_clr alone: sticky_ovf=0 next cycle.
- Write to r0: wb_wen=0, but the entry still retires, updates flags if setflags=1, and counts.
- Forwarding (combinational from buffered state only; never from in_* ports):
  - Candidates are valid entries with wen=1 and rd==src addr and rd!=0.
  - The youngest (tail-most) match wins; with 2 matches the later-pushed entry supplies data.
  - No match: hit=0, data=0.
- Reset asserted mid-operation: all buffered entries are discarded; wb_valid=0 and in_ready=1 after that edge; no flag or counter update from discarded entries; a push or pop in the reset cycle is ignored.

Test Plan:
- Single push {result=0x0000_0005, rd=3, wen=1, setflags=1, flags 0/0/0}, wb_ready=1 -> wb_valid=1 one cycle later with wb_data=5, wb_rd=3, wb_wen=1; after pop flag_z=0, retire_cnt=1.
- Back-pressure: wb_ready=0, push 3 entries -> in_ready=0 after 2nd push; 3rd held; then wb_ready=1 -> entries retire in order A, B, C; count never exceeds 2.
- Forwarding: buffer rd=7 data 0x11 then rd=7 data 0x22, src_a_addr=7 -> fwd_a_hit=1, fwd_a_data=0x22; src_b_addr=0 with an rd=0 entry buffered -> fwd_b_hit=0.
- Flags/sticky: retire {ovf=1, setflags=1} with sticky_clr=1 in the same cycle -> sticky_ovf=1, flag_v=1; next cycle sticky_clr=1 -> sticky_ovf=0; retire {ovf=1, setflags=0} -> flag_v and sticky_ovf unchanged.
- r0 write: push rd=0, wen=1, result 0xFFFF_FFFF, setflags=1, neg=1 -> wb_wen=0, flag_n=1 after retire, retire_cnt increments.
- Reset mid-flight: 2 entries buffered, rst=1 for one cycle -> wb_valid=0, in_ready=1, retire_cnt and flags 0; no stale entry appears afterwards.
